// File: rtl/hrange_arbiter.sv
// hrange_arbiter: shares one hrange generator between NREQ requesters.
// Each requester owns a command slot. One slot at a time is launched on the
// generator, and its value stream and completion pulse are routed back to it.
// Optional feature: define HRANGE_ARB_RR_EN for round-robin arbitration.
// With the macro undefined, fixed priority applies and the lowest pending
// index wins.
//
// Handshake: req_start[i] is a one-cycle strobe. It is accepted only while
// req_busy[i] is 0; otherwise it is dropped. gen_start pulses for exactly one
// cycle per grant. out_valid/out_ready are one-hot and registered. They lag
// gen_valid/gen_ready by one cycle.
module hrange_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 32
) (
    input  logic                      _clock,
    input  logic                      _reset,
    input  logic [NREQ-1:0]           req_start,
    input  logic [NREQ*WIDTH-1:0]     req_base,
    input  logic [NREQ*WIDTH-1:0]     req_limit,
    input  logic [NREQ*WIDTH-1:0]     req_step,
    output logic [NREQ-1:0]           req_busy,
    output logic signed [WIDTH-1:0]   out_0,
    output logic [NREQ-1:0]           out_valid,
    output logic [NREQ-1:0]           out_ready,
    output logic                      gen_start,
    output logic signed [WIDTH-1:0]   gen_base,
    output logic signed [WIDTH-1:0]   gen_limit,
    output logic signed [WIDTH-1:0]   gen_step,
    input  logic signed [WIDTH-1:0]   gen_0,
    input  logic                      gen_valid,
    input  logic                      gen_ready,
    output logic                      o_dbg_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                   r_state;
    logic [NREQ-1:0]          r_busy;
    logic [IW-1:0]            r_grant;
    logic signed [WIDTH-1:0]  r_base  [NREQ];
    logic signed [WIDTH-1:0]  r_limit [NREQ];
    logic signed [WIDTH-1:0]  r_step  [NREQ];
    logic signed [WIDTH-1:0]  r_out_0;
    logic [NREQ-1:0]          r_out_valid;
    logic [NREQ-1:0]          r_out_ready;
    logic                     r_gen_start;
    logic signed [WIDTH-1:0]  r_gen_base;
    logic signed [WIDTH-1:0]  r_gen_limit;
    logic signed [WIDTH-1:0]  r_gen_step;

    logic                     w_found;
    logic [IW-1:0]            w_win;
    logic [NREQ-1:0]          w_grant_oh;

`ifdef HRANGE_ARB_RR_EN
    logic [IW-1:0]            r_rr_ptr;
    int                       w_idx;

    // Round-robin pick: scan starting at the slot after the last grant, with wrap.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % NREQ;
            if (!w_found && r_busy[IW'(w_idx)]) begin
                w_found = 1'b1;
                w_win   = IW'(w_idx);
            end
        end
    end

    // The pointer remembers the last granted slot. It resets to NREQ-1 so slot 0 goes first.
    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            r_rr_ptr <= IW'(NREQ - 1);
        end else if (r_state == S_IDLE && w_found) begin
            r_rr_ptr <= w_win;
        end
    end
`else
    // Fixed-priority pick: the lowest pending slot index wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && r_busy[i]) begin
                w_found = 1'b1;
                w_win   = IW'(i);
            end
        end
    end
`endif

    assign w_grant_oh = NREQ'(1) << r_grant;

    // Latch operands into a free slot when its requester strobes.
    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            for (int i = 0; i < NREQ; i++) begin
                r_base[i]  <= '0;
                r_limit[i] <= '0;
                r_step[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_start[i] && !r_busy[i]) begin
                    r_base[i]  <= req_base[i*WIDTH +: WIDTH];
                    r_limit[i] <= req_limit[i*WIDTH +: WIDTH];
                    r_step[i]  <= req_step[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Grant FSM. It owns the busy flags and all registered outputs.
    // A slot is never set and cleared in the same cycle: set needs busy=0 and clear needs busy=1.
    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            r_state     <= S_IDLE;
            r_busy      <= '0;
            r_grant     <= '0;
            r_out_0     <= '0;
            r_out_valid <= '0;
            r_out_ready <= '0;
            r_gen_start <= 1'b0;
            r_gen_base  <= '0;
            r_gen_limit <= '0;
            r_gen_step  <= '0;
        end else begin
            r_gen_start <= 1'b0;
            r_out_0     <= '0;
            r_out_valid <= '0;
            r_out_ready <= '0;
            for (int i = 0; i < NREQ; i++) begin
                if (req_start[i] && !r_busy[i]) begin
                    r_busy[i] <= 1'b1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant     <= w_win;
                        r_gen_base  <= r_base[w_win];
                        r_gen_limit <= r_limit[w_win];
                        r_gen_step  <= r_step[w_win];
                        r_gen_start <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (gen_valid) begin
                        r_out_0     <= gen_0;
                        r_out_valid <= w_grant_oh;
                    end
                    if (gen_ready) begin
                        r_out_ready      <= w_grant_oh;
                        r_busy[r_grant]  <= 1'b0;
                        r_state          <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_busy    = r_busy;
    assign out_0       = r_out_0;
    assign out_valid   = r_out_valid;
    assign out_ready   = r_out_ready;
    assign gen_start   = r_gen_start;
    assign gen_base    = r_gen_base;
    assign gen_limit   = r_gen_limit;
    assign gen_step    = r_gen_step;
    assign o_dbg_state = (r_state == S_RUN);

endmodule

// File: tb/tb_hrange_arbiter.sv
// Testbench for hrange_arbiter. It contains a behavioural hrange generator
// and a scoreboard queue of expected forwarded events.
module tb_hrange_arbiter;

    localparam int NREQ  = 2;
    localparam int WIDTH = 32;
    localparam int EW    = 1 + NREQ + WIDTH;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NREQ-1:0]          req_start;
    logic [NREQ*WIDTH-1:0]    req_base;
    logic [NREQ*WIDTH-1:0]    req_limit;
    logic [NREQ*WIDTH-1:0]    req_step;
    logic [NREQ-1:0]          req_busy;
    logic signed [WIDTH-1:0]  out_0;
    logic [NREQ-1:0]          out_valid;
    logic [NREQ-1:0]          out_ready;
    logic                     gen_start;
    logic signed [WIDTH-1:0]  gen_base;
    logic signed [WIDTH-1:0]  gen_limit;
    logic signed [WIDTH-1:0]  gen_step;
    logic signed [WIDTH-1:0]  gen_0;
    logic                     gen_valid;
    logic                     gen_ready;
    logic                     dbg_state;

    logic [EW-1:0] exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;
    int pop_cnt  = 0;

    // clock / reset
    always #5 clk = ~clk;

    hrange_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        ._clock      (clk),
        ._reset      (rst),
        .req_start   (req_start),
        .req_base    (req_base),
        .req_limit   (req_limit),
        .req_step    (req_step),
        .req_busy    (req_busy),
        .out_0       (out_0),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .gen_start   (gen_start),
        .gen_base    (gen_base),
        .gen_limit   (gen_limit),
        .gen_step    (gen_step),
        .gen_0       (gen_0),
        .gen_valid   (gen_valid),
        .gen_ready   (gen_ready),
        .o_dbg_state (dbg_state)
    );

    function automatic logic in_rng(logic signed [WIDTH-1:0] v,
                                    logic signed [WIDTH-1:0] l,
                                    logic signed [WIDTH-1:0] s);
        if (s > 0) return v < l;
        if (s < 0) return v > l;
        return 1'b0;
    endfunction

    // generator model: the first value or the empty-range ready comes one cycle after gen_start
    logic                     g_active;
    logic signed [WIDTH-1:0]  g_cur;
    logic signed [WIDTH-1:0]  g_lim;
    logic signed [WIDTH-1:0]  g_stp;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_0 <= '0; gen_valid <= 1'b0; gen_ready <= 1'b0;
            g_active <= 1'b0; g_cur <= '0; g_lim <= '0; g_stp <= '0;
        end else begin
            gen_valid <= 1'b0;
            gen_ready <= 1'b0;
            if (gen_start) begin
                g_lim <= gen_limit;
                g_stp <= gen_step;
                if (in_rng(gen_base, gen_limit, gen_step)) begin
                    gen_valid <= 1'b1;
                    gen_0     <= gen_base;
                    g_cur     <= gen_base + gen_step;
                    g_active  <= 1'b1;
                end else begin
                    gen_ready <= 1'b1;
                end
            end else if (g_active) begin
                if (in_rng(g_cur, g_lim, g_stp)) begin
                    gen_valid <= 1'b1;
                    gen_0     <= g_cur;
                    g_cur     <= g_cur + g_stp;
                end else begin
                    gen_ready <= 1'b1;
                    g_active  <= 1'b0;
                end
            end
        end
    end

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: pop and compare every forwarded event
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst) begin
            if (out_valid == '0) check("out_0_zero_when_invalid", 64'(out_0), 64'd0);
            if (out_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_value", 64'({1'b0, out_valid, out_0}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("value", 64'({1'b0, out_valid, out_0}), 64'(e));
                end
                pop_cnt++;
            end
            if (out_ready != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 64'({1'b1, out_ready}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ready", 64'({1'b1, out_ready, {WIDTH{1'b0}}}), 64'(e));
                end
                pop_cnt++;
            end
        end
    end

    // driver tasks
    task automatic push_job(int i, int b, int l, int s);
        logic signed [WIDTH-1:0] v;
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[i] = 1'b1;
        v = b;
        while (in_rng(v, l, s)) begin
            exp_q.push_back({1'b0, oh, v});
            v = v + s;
        end
        exp_q.push_back({1'b1, oh, {WIDTH{1'b0}}});
    endtask

    task automatic post(logic [NREQ-1:0] mask, int b, int l, int s);
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (mask[i]) begin
                req_base[i*WIDTH +: WIDTH]  = b;
                req_limit[i*WIDTH +: WIDTH] = l;
                req_step[i*WIDTH +: WIDTH]  = s;
            end
        end
        req_start = mask;
        @(posedge clk);
        #1;
        req_start = '0;
    endtask

    task automatic wait_done(string tag);
        int cyc;
        cyc = 0;
        while ((req_busy != '0 || exp_q.size() != 0) && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check(tag, 64'(cyc >= 300), 64'd0);
    endtask

    task automatic wait_ready(logic [NREQ-1:0] mask, string tag);
        int cyc;
        cyc = 0;
        while (out_ready != mask && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check(tag, 64'(cyc >= 100), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // directed stimulus
    initial begin
        int target;
        int cyc;
        rst = 1'b1;
        req_start = '0;
        req_base = '0;
        req_limit = '0;
        req_step = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_busy",      64'(req_busy),  64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_ready", 64'(out_ready), 64'd0);
        check("rst_out_0",     64'(out_0),     64'd0);
        check("rst_gen_start", 64'(gen_start), 64'd0);
        check("rst_gen_ops",   64'({gen_base, gen_limit}), 64'd0);
        check("rst_state",     64'(dbg_state), 64'd0);

        // single job: 0,1,2 then ready
        push_job(0, 0, 3, 1);
        post(2'b01, 0, 3, 1);
        check("single_busy_set", 64'(req_busy), 64'd1);
        @(posedge clk); #1;
        check("single_gen_start", 64'(gen_start), 64'd1);
        check("single_gen_base",  64'(gen_base),  64'd0);
        check("single_gen_limit", 64'(gen_limit), 64'd3);
        check("single_gen_step",  64'(gen_step),  64'd1);
        @(posedge clk); #1;
        check("single_start_one_cycle", 64'(gen_start), 64'd0);
        check("single_no_early_value",  64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("single_first_value_lat3", 64'({out_valid, out_0}), 64'({2'b01, 32'sd0}));
        wait_done("single_done");
        check("single_hold_limit", 64'(gen_limit), 64'd3);

        // empty range: ready three cycles after the strobe
        push_job(1, 5, 5, 1);
        post(2'b10, 5, 5, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("empty_no_early_ready", 64'(out_ready), 64'd0);
        @(posedge clk); #1;
        check("empty_ready_lat3", 64'(out_ready), 64'b10);
        check("empty_busy_clear", 64'(req_busy), 64'd0);
        wait_done("empty_done");

        // contention round 1: req0 first in both modes
        push_job(0, 0, 2, 1);
        push_job(1, 0, 2, 1);
        post(2'b11, 0, 2, 1);
        check("cont1_both_busy", 64'(req_busy), 64'b11);
        wait_ready(2'b01, "cont1_wait_ready0");
        @(posedge clk); #1;
        check("cont1_regrant_bubble", 64'(gen_start), 64'd1);
        wait_done("cont1_done");

        // dropped strobe while busy
        push_job(0, 0, 3, 1);
        post(2'b01, 0, 3, 1);
        post(2'b01, 100, 103, 1);
        check("drop_busy_held", 64'(req_busy), 64'd1);
        wait_done("drop_done");
        check("drop_busy_clear", 64'(req_busy), 64'd0);

        // negative base with positive step
        push_job(0, -4, 2, 3);
        post(2'b01, -4, 2, 3);
        wait_done("neg_done");

        // contention round 2: the last grant was req0
`ifdef HRANGE_ARB_RR_EN
        push_job(1, 0, 2, 1);
        push_job(0, 0, 2, 1);
`else
        push_job(0, 0, 2, 1);
        push_job(1, 0, 2, 1);
`endif
        post(2'b11, 0, 2, 1);
        wait_done("cont2_done");

        // reset during a long run
        push_job(0, 0, 100, 1);
        post(2'b01, 0, 100, 1);
        target = pop_cnt + 3;
        cyc = 0;
        while (pop_cnt < target && cyc < 50) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        check("rstrun_three_values", 64'(cyc >= 50), 64'd0);
        rst = 1'b1;
        #1;
        check("rstrun_outs_zero", 64'({out_valid, out_ready, out_0}), 64'd0);
        check("rstrun_busy_zero", 64'({req_busy, gen_start, dbg_state}), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        check("rstrun_no_ready", 64'(out_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        push_job(1, 0, 1, 1);
        post(2'b10, 0, 1, 1);
        wait_done("rstrun_after_done");

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
